// File: rtl/sort_stream_adapter.sv
// rtl/sort_stream_adapter.sv - 8-word valid/ready stream front end for the 8x32 sorter
// Optional abort on a stalled sorter: define SORT_TIMEOUT_EN.
module sort_stream_adapter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         sort_rst,
  output logic         sort_start,
  output logic [W-1:0] sort_in0,
  output logic [W-1:0] sort_in1,
  output logic [W-1:0] sort_in2,
  output logic [W-1:0] sort_in3,
  output logic [W-1:0] sort_in4,
  output logic [W-1:0] sort_in5,
  output logic [W-1:0] sort_in6,
  output logic [W-1:0] sort_in7,
  input  logic [W-1:0] sort_out0,
  input  logic [W-1:0] sort_out1,
  input  logic [W-1:0] sort_out2,
  input  logic [W-1:0] sort_out3,
  input  logic [W-1:0] sort_out4,
  input  logic [W-1:0] sort_out5,
  input  logic [W-1:0] sort_out6,
  input  logic [W-1:0] sort_out7,
  input  logic         sort_done,
  output logic         busy,
  output logic         err
);
  typedef enum logic [1:0] {LOAD, SRST, START, DRAIN} state_t;

  state_t       state, next_state;
  logic [2:0]   cnt, cnt_nxt;
  logic [W-1:0] buf_r   [8];
  logic [W-1:0] buf_nxt [8];
  logic [W-1:0] sort_out [8];
  logic         s_hs, m_hs, abort;
  logic         s_ready_d, m_valid_d, m_last_d, sort_rst_d, sort_start_d, busy_d;
  logic [W-1:0] m_data_d;

  assign sort_out[0] = sort_out0;
  assign sort_out[1] = sort_out1;
  assign sort_out[2] = sort_out2;
  assign sort_out[3] = sort_out3;
  assign sort_out[4] = sort_out4;
  assign sort_out[5] = sort_out5;
  assign sort_out[6] = sort_out6;
  assign sort_out[7] = sort_out7;

  // The operand buffer is itself the register feeding the sorter.
  assign sort_in0 = buf_r[0];
  assign sort_in1 = buf_r[1];
  assign sort_in2 = buf_r[2];
  assign sort_in3 = buf_r[3];
  assign sort_in4 = buf_r[4];
  assign sort_in5 = buf_r[5];
  assign sort_in6 = buf_r[6];
  assign sort_in7 = buf_r[7];

  assign s_hs = s_valid && s_ready;
  assign m_hs = m_valid && m_ready;

`ifdef SORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                tcnt <= '0;
    else if (state != START) tcnt <= '0;
    else                     tcnt <= tcnt + TW'(1);
  end

  // Fires in the TIMEOUT-th START cycle; a simultaneous done wins.
  assign abort = (state == START) && !sort_done && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          err <= 1'b0;
    else if (abort)                    err <= 1'b1;
    else if (s_hs && cnt == 3'd0)      err <= 1'b0;
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      cnt        <= '0;
      for (int k = 0; k < 8; k++) buf_r[k] <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_data     <= '0;
      sort_rst   <= 1'b1;
      sort_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_nxt;
      buf_r      <= buf_nxt;
      s_ready    <= s_ready_d;
      m_valid    <= m_valid_d;
      m_last     <= m_last_d;
      m_data     <= m_data_d;
      sort_rst   <= sort_rst_d;
      sort_start <= sort_start_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (s_hs && cnt == 3'd7) next_state = SRST;
      SRST:    next_state = START;
      START:   if (sort_done || abort) next_state = DRAIN;
      DRAIN:   if (m_hs && cnt == 3'd7) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // Next datapath values, then outputs registered from the next state.
  always_comb begin
    cnt_nxt = cnt;
    for (int k = 0; k < 8; k++) buf_nxt[k] = buf_r[k];
    if (s_hs) begin
      buf_nxt[cnt] = s_data;
      cnt_nxt      = cnt + 3'd1;
    end
    if (m_hs) cnt_nxt = cnt + 3'd1;
    if (state == START && sort_done)
      for (int k = 0; k < 8; k++) buf_nxt[k] = sort_out[k];

    s_ready_d    = (next_state == LOAD);
    sort_rst_d   = (next_state == SRST);
    sort_start_d = (next_state == START);
    m_valid_d    = (next_state == DRAIN);
    m_last_d     = m_valid_d && (cnt_nxt == 3'd7);
    m_data_d     = m_valid_d ? buf_nxt[cnt_nxt] : m_data;
    busy_d       = (next_state != LOAD);
  end
endmodule

// File: tb/tb_sort_stream_adapter.sv
// tb/tb_sort_stream_adapter.sv - scoreboard bench for sort_stream_adapter with a behavioural sorter
module tb_sort_stream_adapter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        sort_rst, sort_start, sort_done = 1'b0;
  logic [31:0] si [8];
  logic [31:0] so [8];
  logic        busy, err;

  int checks = 0, failures = 0;
  logic [31:0] exp_d[$];
  bit          exp_l[$];
  int          ready_mode = 0;
  int          out_cnt = 0;
  bit          sorter_dead = 1'b0;

  always #5 clk = ~clk;

  sort_stream_adapter #(.W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sort_rst(sort_rst), .sort_start(sort_start),
    .sort_in0(si[0]), .sort_in1(si[1]), .sort_in2(si[2]), .sort_in3(si[3]),
    .sort_in4(si[4]), .sort_in5(si[5]), .sort_in6(si[6]), .sort_in7(si[7]),
    .sort_out0(so[0]), .sort_out1(so[1]), .sort_out2(so[2]), .sort_out3(so[3]),
    .sort_out4(so[4]), .sort_out5(so[5]), .sort_out6(so[6]), .sort_out7(so[7]),
    .sort_done(sort_done), .busy(busy), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Sorter stand-in: sticky done, one load per reset, a few cycles of latency.
  logic [31:0] sres [$];
  bit          loaded = 1'b0;
  int          sdelay = 0;
  initial for (int k = 0; k < 8; k++) so[k] = '0;
  always @(negedge clk) begin
    if (sort_rst) begin
      sort_done = 1'b0; loaded = 1'b0; sdelay = 0;
    end else if (sort_start && !loaded) begin
      loaded = 1'b1;
      sres.delete();
      for (int k = 0; k < 8; k++) sres.push_back(si[k]);
      sres.sort();
      sdelay = $urandom_range(1, 5);
    end else if (loaded && !sort_done && !sorter_dead) begin
      sdelay--;
      if (sdelay == 0) begin
        for (int k = 0; k < 8; k++) so[k] = sres[k];
        sort_done = 1'b1;
      end
    end
  end

  // Output monitor: drives m_ready, pops the scoreboard on each handshake.
  bit          stall_pend = 1'b0;
  logic [31:0] stall_d;
  logic        stall_l;
  always @(negedge clk) begin
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    if (!rst) stall_pend = 1'b0;
    else if (m_valid) begin
      if (stall_pend) begin
        check("stall_data", m_data, stall_d);
        check("stall_last", 32'(m_last), 32'(stall_l));
      end
      if (m_ready) begin
        if (exp_d.size() == 0) check("unexpected_output", m_data, 32'hx);
        else begin
          check("out_data", m_data, exp_d.pop_front());
          check("out_last", 32'(m_last), 32'(exp_l.pop_front()));
        end
        out_cnt++;
        stall_pend = 1'b0;
      end else begin
        stall_pend = 1'b1; stall_d = m_data; stall_l = m_last;
      end
    end
  end

  // Done sampled at edge D must show the first output word from D.
  always @(negedge clk) begin
    if (rst && sort_start && sort_done) begin
      @(posedge clk); #1;
      check("mvalid_at_done", 32'(m_valid), 32'd1);
      check("start_drop_at_done", 32'(sort_start), 32'd0);
    end
  end

  task automatic send_word(input logic [31:0] d, input int gap);
    int n = 0;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    s_valid = 1'b1; s_data = d;
    while (!s_ready && n < 2000) begin @(negedge clk); n++; end
    if (!s_ready) begin
      check("s_accept_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] w[8], input bit sorted);
    logic [31:0] q[$];
    for (int k = 0; k < 8; k++) q.push_back(w[k]);
    if (sorted) q.sort();
    for (int k = 0; k < 8; k++) begin exp_d.push_back(q[k]); exp_l.push_back(k == 7); end
  endtask

  task automatic run_job(input logic [31:0] w[8], input int maxgap);
    push_exp(w, 1'b1);
    for (int k = 0; k < 8; k++) send_word(w[k], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    check("srst_pulse", 32'(sort_rst), 32'd1);
    check("start_before_srst", 32'(sort_start), 32'd0);
    check("busy_srst", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) check($sformatf("sort_in%0d", k), si[k], w[k]);
    @(posedge clk); #1;
    check("srst_one_cycle", 32'(sort_rst), 32'd0);
    check("start_rise", 32'(sort_start), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_d.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    check("drain_timeout", exp_d.size(), 0);
  endtask

  initial begin
    logic [31:0] w [8];
    int base, n;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_sort_rst", 32'(sort_rst), 32'd1);
    check("rst_sort_start", 32'(sort_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sort_in0", si[0], 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("release_s_ready", 32'(s_ready), 32'd1);
    check("release_sort_rst", 32'(sort_rst), 32'd0);

    w = '{7, 3, 5, 1, 8, 2, 6, 4};
    ready_mode = 0; run_job(w, 0); wait_drain();
    ready_mode = 1; run_job(w, 3); wait_drain();

    ready_mode = 0;
    w = '{32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0};
    run_job(w, 0);
    w = '{5, 5, 5, 5, 5, 5, 5, 5};
    run_job(w, 0);
    wait_drain();

    for (int j = 0; j < 3; j++) begin
      ready_mode = 2;
      for (int k = 0; k < 8; k++) w[k] = (j == 1) ? $urandom_range(0, 7) : $urandom;
      run_job(w, 2); wait_drain();
    end

    // Reset during the output phase after three words.
    ready_mode = 0;
    base = out_cnt;
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    run_job(w, 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (out_cnt < base + 3 && n < 2000);
    check("mid_reset_reach", 32'(out_cnt >= base + 3), 32'd1);
    rst = 1'b0; #1;
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_sort_rst", 32'(sort_rst), 32'd1);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    exp_d.delete(); exp_l.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    check("rerelease_s_ready_low", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("rerelease_s_ready", 32'(s_ready), 32'd1);
    w = '{7, 3, 5, 1, 8, 2, 6, 4};
    run_job(w, 1); wait_drain();
    check("err_default", 32'(err), 32'd0);

`ifdef SORT_TIMEOUT_EN
    sorter_dead = 1'b1;
    w = '{9, 8, 7, 6, 5, 4, 3, 2};
    push_exp(w, 1'b0);
    for (int k = 0; k < 8; k++) send_word(w[k], 0);
    @(posedge clk); #1;
    check("to_start", 32'(sort_start), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    check("to_err_early", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("to_err", 32'(err), 32'd1);
    check("to_m_valid", 32'(m_valid), 32'd1);
    check("to_start_drop", 32'(sort_start), 32'd0);
    wait_drain();
    sorter_dead = 1'b0;
    check("to_err_sticky", 32'(err), 32'd1);
    w = '{4, 1, 3, 2, 8, 6, 7, 5};
    push_exp(w, 1'b1);
    send_word(w[0], 0);
    check("to_err_clear", 32'(err), 32'd0);
    for (int k = 1; k < 8; k++) send_word(w[k], 0);
    wait_drain();
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
